ahb_lite_master: RTL
====================

// Module: ahb_lite_master
// PURPOSE
//  AHB-Lite initiator. Turns a valid/ready command stream into single AHB transfers that drive the PORT-style slaves.
//  Address and data phases are pipelined, so a new address phase can overlap the previous data phase.
//  Each command returns exactly one response pulse, in command order. Bridge for debug/DMA-type requesters.
// PARAMETERS
//  HPROT_DEF  4'b0011  constant value driven on M_HPROT (data access, privileged)
// PORTS
//  CLK          in   1   clock; all logic on posedge
//  RES          in   1   reset, synchronous, active-high
//  CMD_VALID    in   1   command present
//  CMD_READY    out  1   command accepted when CMD_VALID & CMD_READY
//  CMD_WRITE    in   1   1=write 0=read
//  CMD_SIZE     in   3   HSIZE encoding; 0=byte 1=half 2=word
//  CMD_ADDR     in   32  byte address
//  CMD_WDATA    in   32  write data, already placed on the correct byte lanes
//  RSP_VALID    out  1   one-cycle response pulse; no backpressure
//  RSP_ERROR    out  1   transfer failed (HRESP error, misaligned or cancelled)
//  RSP_RDATA    out  32  read data (HRDATA raw); 0 for writes and errors
//  M_HTRANS     out  2   00 IDLE / 10 NONSEQ only
//  M_HWRITE     out  1   address-phase write flag
//  M_HMASTLOCK  out  1   constant 0
//  M_HSIZE      out  3   address-phase size
//  M_HBURST     out  3   constant 000 (SINGLE)
//  M_HPROT      out  4   constant HPROT_DEF
//  M_HADDR      out  32  address-phase address
//  M_HWDATA     out  32  data-phase write data
//  M_HREADY     in   1   bus ready (HREADYOUT of selected slave)
//  M_HRDATA     in   32  read data
//  M_HRESP      in   1   1=ERROR
// BEHAVIOUR
//  Reset (RES=1 at a clock edge): aphase/dphase/pending-cancel cleared; outputs become HTRANS=00, HADDR=0, HWRITE=0,
//   HSIZE=0, HWDATA=0, RSP_VALID=0, RSP_ERROR=0, RSP_RDATA=0. Clears mid-transfer unconditionally; no response for lost transfers.
//  All AHB outputs are registered. Address-phase register (aphase) holds valid, addr, write, size, wdata.
//  Accept: CMD_READY = ~RES & ~cancel_pend & (~aphase.v | M_HREADY) & ~(dphase.v & M_HRESP).
//   A command accepted at edge N drives HTRANS=10 with HADDR/HWRITE/HSIZE from cycle N+1.
//  Address phase holds stable while M_HREADY=0. When M_HREADY=1 it moves to dphase (valid, write, wdata).
//   HWDATA=dphase.wdata during the data phase. Back-to-back acceptance gives continuous NONSEQ with no IDLE gap.
//  Without a new command, HTRANS returns to 00. HADDR keeps its last value; HWRITE=0.
//  Data phase completes at the edge where dphase.v & M_HREADY. The following cycle gives RSP_VALID=1,
//   RSP_ERROR=M_HRESP, and RSP_RDATA=M_HRDATA for a successful read, else 0.
//  Zero-wait-state read latency: accept N, address N+1, data N+2, RSP_VALID in N+3.
//  Error (two-cycle AHB ERROR):
//   - 1st cycle (dphase.v & M_HRESP & ~M_HREADY): if aphase.v, HTRANS goes to 00 for the 2nd cycle and the command is cancelled.
//     cancel_pend is set and no new command is accepted.
//   - 2nd cycle (M_HRESP & M_HREADY): the errored transfer responds next cycle with RSP_ERROR=1.
//   - The cancelled command responds the cycle after that with RSP_ERROR=1, then cancel_pend clears.
//  Misaligned (SIZE=1 & ADDR[0], SIZE=2 & ADDR[1:0]!=0) or SIZE>2:
//   - accepted only when aphase and dphase are both empty and cancel_pend=0; otherwise CMD_READY=0;
//   - never reaches the bus (HTRANS stays 00);
//   - RSP_VALID=1 with RSP_ERROR=1 in the cycle after acceptance.
//  Ordering: at most 2 transfers in flight. Responses are strictly in acceptance order and never coincide, so one RSP register is enough.
//  Wait states: any number of M_HREADY=0 cycles; no timeout.
// TESTING
//  1. Single word write 0x40000010 <= 0xA5A5_0F0F, HREADY=1: NONSEQ 1 cycle, HWDATA=0xA5A50F0F next cycle, RSP_VALID 1 cycle later, RSP_ERROR=0.
//  2. Four back-to-back reads, slave returns 0x11,0x22,0x33,0x44, zero wait: HTRANS=10 for 4 consecutive cycles; RSP_RDATA 0x11..0x44 on 4 consecutive cycles.
//  3. Write, then read, with HREADY low 3 cycles in the first data phase: read address held stable 3 cycles; CMD_READY=0 throughout; both responses in order.
//  4. Error on 1st of 2 pipelined reads: HTRANS=00 in 2nd error cycle; two RSP_VALID pulses with RSP_ERROR=1 on consecutive cycles; the 2nd read never appears on the bus.
//  5. Misaligned word read at 0x...02, and SIZE=3: no bus activity; RSP_ERROR=1 the cycle after acceptance; CMD_READY=0 while a transfer is in flight.
//  6. RES asserted during a wait-stated data phase: next cycle HTRANS=00, RSP_VALID=0; a new command afterwards completes normally.

Source files
------------

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: converts a valid/ready command stream into pipelined SINGLE/NONSEQ transfers
// and returns one in-order response pulse per command.
module ahb_lite_master #(
    parameter logic [3:0] HPROT_DEF = 4'b0011
) (
    input  logic        i_clk,
    input  logic        i_res,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [2:0]  i_cmd_size,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    output logic        o_rsp_valid,
    output logic        o_rsp_error,
    output logic [31:0] o_rsp_rdata,
    output logic [1:0]  o_m_htrans,
    output logic        o_m_hwrite,
    output logic        o_m_hmastlock,
    output logic [2:0]  o_m_hsize,
    output logic [2:0]  o_m_hburst,
    output logic [3:0]  o_m_hprot,
    output logic [31:0] o_m_haddr,
    output logic [31:0] o_m_hwdata,
    input  logic        i_m_hready,
    input  logic [31:0] i_m_hrdata,
    input  logic        i_m_hresp
);

    // Illegal sizes and unaligned addresses are answered locally and never reach the bus.
    function automatic logic f_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            3'd0:    bad = 1'b0;
            3'd1:    bad = addr_lo[0];
            3'd2:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // address phase
    logic        r_a_v;
    logic [31:0] r_a_addr;
    logic        r_a_write;
    logic [2:0]  r_a_size;
    logic [31:0] r_a_wdata;
    // data phase
    logic        r_d_v;
    logic        r_d_write;
    logic [31:0] r_d_wdata;
    // cancelled-command bookkeeping and response
    logic        r_cancel;
    logic        r_rsp_v;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic w_bad;
    logic w_err1;
    logic w_a_adv;
    logic w_d_done;
    logic w_ready;
    logic w_accept;

    // Handshake and phase-transition decode.
    always_comb begin
        w_bad    = f_misaligned(i_cmd_size, i_cmd_addr[1:0]);
        w_err1   = r_d_v & i_m_hresp & ~i_m_hready;
        w_a_adv  = r_a_v & i_m_hready;
        w_d_done = r_d_v & i_m_hready;
        w_ready  = ~i_res & ~r_cancel & (~r_a_v | i_m_hready) & ~(r_d_v & i_m_hresp)
                   & (~w_bad | (~r_a_v & ~r_d_v));
        w_accept = i_cmd_valid & w_ready;
    end

    // Address-phase register; on the first ERROR cycle the queued command is withdrawn from the bus.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_a_v     <= 1'b0;
            r_a_addr  <= 32'd0;
            r_a_write <= 1'b0;
            r_a_size  <= 3'd0;
            r_a_wdata <= 32'd0;
        end else if (w_err1 && r_a_v) begin
            r_a_v     <= 1'b0;
            r_a_write <= 1'b0;
        end else if (w_accept && !w_bad) begin
            r_a_v     <= 1'b1;
            r_a_addr  <= i_cmd_addr;
            r_a_write <= i_cmd_write;
            r_a_size  <= i_cmd_size;
            r_a_wdata <= i_cmd_wdata;
        end else if (w_a_adv) begin
            r_a_v     <= 1'b0;
            r_a_write <= 1'b0;
        end else begin
            r_a_v     <= r_a_v;
            r_a_write <= r_a_write;
        end
    end

    // Data-phase register; HWDATA keeps its last value once the phase ends.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_d_v     <= 1'b0;
            r_d_write <= 1'b0;
            r_d_wdata <= 32'd0;
        end else if (w_a_adv) begin
            r_d_v     <= 1'b1;
            r_d_write <= r_a_write;
            r_d_wdata <= r_a_wdata;
        end else if (w_d_done) begin
            r_d_v     <= 1'b0;
        end else begin
            r_d_v     <= r_d_v;
        end
    end

    // Pending cancel: set when a queued command is dropped, cleared once its error response is issued.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_cancel <= 1'b0;
        end else if (w_err1 && r_a_v) begin
            r_cancel <= 1'b1;
        end else if (r_cancel && !r_d_v) begin
            r_cancel <= 1'b0;
        end else begin
            r_cancel <= r_cancel;
        end
    end

    // Response register; the sources are mutually exclusive in time, so one register suffices.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_rsp_v     <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else if (w_d_done) begin
            r_rsp_v     <= 1'b1;
            r_rsp_err   <= i_m_hresp;
            r_rsp_rdata <= (!r_d_write && !i_m_hresp) ? i_m_hrdata : 32'd0;
        end else if (r_cancel && !r_d_v) begin
            r_rsp_v     <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= 32'd0;
        end else if (w_accept && w_bad) begin
            r_rsp_v     <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= 32'd0;
        end else begin
            r_rsp_v     <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end
    end

    assign o_cmd_ready   = w_ready;
    assign o_rsp_valid   = r_rsp_v;
    assign o_rsp_error   = r_rsp_err;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_m_htrans    = {r_a_v, 1'b0};
    assign o_m_hwrite    = r_a_write;
    assign o_m_hmastlock = 1'b0;
    assign o_m_hsize     = r_a_size;
    assign o_m_hburst    = 3'b000;
    assign o_m_hprot     = HPROT_DEF;
    assign o_m_haddr     = r_a_addr;
    assign o_m_hwdata    = r_d_wdata;

endmodule
